// File: rtl/spike_packet_receiver_pkg.sv
// Shared spike-packet definitions for the receive path and the network_interface.
// Packet layout: origin neuron address in the upper field, destination in the lower field.
package spike_packet_receiver_pkg;

  localparam int ADDR_W     = 12;
  localparam int PKT_W      = 2 * ADDR_W;
  localparam int ORIGIN_MSB = 23;
  localparam int ORIGIN_LSB = 12;
  localparam int DEST_MSB   = 11;
  localparam int DEST_LSB   = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } rx_state_t;

endpackage

// File: rtl/spike_packet_fifo.sv
// Synchronous FIFO with push/pop/full/empty/count; head is presented combinationally.
// Pushes while full and pops while empty are ignored.
module spike_packet_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_dat,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_pop_dat,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spike_packet_receiver.sv
// Buffers incoming spike packets, range-checks the destination and strobes the origin into a neuron slot.
// Accept-to-strobe is two edges; a busy target neuron blocks the queue head, and a full FIFO drops in_ready.
module spike_packet_receiver #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          clear,
  input  logic [ADDR_W-1:0]             base_address,
  input  logic                          in_valid,
  input  logic [2*ADDR_W-1:0]           in_packet,
  output logic                          in_ready,
  input  logic [NUM_NEURONS-1:0]        neuron_busy,
  output logic [ADDR_W*NUM_NEURONS-1:0] source_addresses,
  output logic [NUM_NEURONS-1:0]        source_valid,
  output logic [7:0]                    drop_count,
  output logic                          fifo_empty,
  output logic                          fifo_full
);

  import spike_packet_receiver_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  rx_state_t                           r_state;
  rx_state_t                           w_state_nxt;
  logic [PKT_W-1:0]                    r_hold;
  logic [PKT_W-1:0]                    w_fifo_dat;
  logic [CNT_W-1:0]                    w_fifo_count;
  logic                                w_push;
  logic                                w_pop;
  logic                                w_deliver;
  logic                                w_drop;
  logic                                w_in_range;
  logic                                w_busy;
  logic [ADDR_W-1:0]                   w_dest;
  logic [ADDR_W-1:0]                   w_origin;
  logic [ADDR_W-1:0]                   w_idx;
  logic [NUM_NEURONS-1:0][ADDR_W-1:0]  r_src;
  logic [NUM_NEURONS-1:0]              r_src_vld;
  logic [7:0]                          r_drop_cnt;

  assign in_ready = (w_fifo_count != CNT_W'(FIFO_DEPTH)) && !clear;
  assign w_push   = in_valid && in_ready;

  spike_packet_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (CLK),
    .i_clear    (clear),
    .i_push     (w_push),
    .i_push_dat (in_packet),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_count    (w_fifo_count)
  );

  assign w_dest   = r_hold[DEST_MSB:DEST_LSB];
  assign w_origin = r_hold[ORIGIN_MSB:ORIGIN_LSB];

  // Destinations below base wrap to large values and fall out of range.
  assign w_idx      = w_dest - base_address;
  assign w_in_range = (w_idx < ADDR_W'(NUM_NEURONS));

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (w_idx == ADDR_W'(i)) w_busy = neuron_busy[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_deliver   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!w_in_range) begin
          w_drop = 1'b1;
        end else if (!w_busy) begin
          w_deliver = 1'b1;
        end
        if (w_drop || w_deliver) begin
          if (!fifo_empty) w_pop = 1'b1;
          else             w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_hold <= w_fifo_dat;
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      r_src      <= '0;
      r_src_vld  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_src_vld <= '0;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      if (w_deliver) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if (w_idx == ADDR_W'(i)) begin
            r_src[i]     <= w_origin;
            r_src_vld[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign source_addresses = r_src;
  assign source_valid     = r_src_vld;
  assign drop_count       = r_drop_cnt;

endmodule

// File: tb/tb_spike_packet_receiver.sv
// Scoreboard bench: expected deliveries are queued at acceptance and checked when a strobe appears.
module tb_spike_packet_receiver;

  localparam int NN = 10;
  localparam int AW = 12;

  logic              CLK = 1'b0;
  logic              clear = 1'b1;
  logic [AW-1:0]     base_address = 12'h010;
  logic              in_valid = 1'b0;
  logic [2*AW-1:0]   in_packet = '0;
  logic              in_ready;
  logic [NN-1:0]     neuron_busy = '0;
  logic [AW*NN-1:0]  source_addresses;
  logic [NN-1:0]     source_valid;
  logic [7:0]        drop_count;
  logic              fifo_empty;
  logic              fifo_full;

  int checks = 0;
  int failures = 0;
  int n_strobes = 0;
  int exp_drops = 0;

  typedef struct {
    int          idx;
    logic [11:0] origin;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [NN-1:0] mon_vld;

  always #5 CLK = ~CLK;

  spike_packet_receiver #(
    .NUM_NEURONS (NN),
    .ADDR_W      (AW),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK              (CLK),
    .clear            (clear),
    .base_address     (base_address),
    .in_valid         (in_valid),
    .in_packet        (in_packet),
    .in_ready         (in_ready),
    .neuron_busy      (neuron_busy),
    .source_addresses (source_addresses),
    .source_valid     (source_valid),
    .drop_count       (drop_count),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full)
  );

  always @(negedge CLK) begin
    if (!clear && source_valid != '0) begin
      n_strobes++;
      checks++;
      if ($countones(source_valid) != 1) begin
        failures++;
        $display("FAIL strobe_onehot source_valid=%b required one-hot", source_valid);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe source_valid=%b required none", source_valid);
      end else begin
        mon_e   = sb.pop_front();
        mon_vld = '0;
        mon_vld[mon_e.idx] = 1'b1;
        if (source_valid !== mon_vld || source_addresses[mon_e.idx*AW +: AW] !== mon_e.origin) begin
          failures++;
          $display("FAIL delivery source_valid=%b slot=%h required source_valid=%b slot=%h",
                   source_valid, source_addresses[mon_e.idx*AW +: AW], mon_vld, mon_e.origin);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [11:0] o, input logic [11:0] d);
    int n;
    logic [11:0] idx;
    in_valid  = 1'b1;
    in_packet = {o, d};
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end else begin
      idx = d - base_address;
      if (idx < NN) sb.push_back('{int'(idx), o});
      else if (exp_drops < 255) exp_drops++;
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0 || fifo_empty !== 1'b1 || source_valid !== '0 ||
        source_addresses !== '0 || drop_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_state in_ready=%b empty=%b vld=%b addrs=%h drops=%0d required 0 1 0 0 0",
               in_ready, fifo_empty, source_valid, source_addresses, drop_count);
    end
    clear = 1'b0;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic_delivery();
    send(12'h0A3, 12'h013);
    @(negedge CLK);
    checks++;
    if (source_valid !== '0) begin
      failures++;
      $display("FAIL early_strobe source_valid=%b required 0", source_valid);
    end
    @(negedge CLK);
    checks++;
    if (source_valid !== 10'b0000001000 || source_addresses[3*AW +: AW] !== 12'h0A3) begin
      failures++;
      $display("FAIL basic_latency source_valid=%b slot3=%h required 0000001000 0a3",
               source_valid, source_addresses[3*AW +: AW]);
    end
    @(negedge CLK);
    checks++;
    if (source_valid !== '0) begin
      failures++;
      $display("FAIL strobe_width source_valid=%b required 0", source_valid);
    end
  endtask

  task automatic test_drops();
    int s0;
    s0 = n_strobes;
    send(12'h0AA, 12'h01A);
    send(12'h0BB, 12'h00F);
    repeat (3) @(negedge CLK);
    checks++;
    if (drop_count !== 8'(exp_drops) || n_strobes != s0) begin
      failures++;
      $display("FAIL out_of_range drops=%0d strobes=%0d required drops=%0d strobes=%0d",
               drop_count, n_strobes - s0, exp_drops, 0);
    end
  endtask

  task automatic test_busy();
    int s0;
    s0 = n_strobes;
    neuron_busy = 10'b0000001000;
    send(12'h001, 12'h013);
    send(12'h002, 12'h014);
    repeat (4) @(negedge CLK);
    checks++;
    if (n_strobes != s0) begin
      failures++;
      $display("FAIL busy_hold strobes=%0d required 0", n_strobes - s0);
    end
    neuron_busy = '0;
    @(negedge CLK);
    checks++;
    if (source_valid !== 10'b0000001000 || source_addresses[3*AW +: AW] !== 12'h001) begin
      failures++;
      $display("FAIL busy_release_first vld=%b slot3=%h required 0000001000 001",
               source_valid, source_addresses[3*AW +: AW]);
    end
    @(negedge CLK);
    checks++;
    if (source_valid !== 10'b0000010000 || source_addresses[4*AW +: AW] !== 12'h002) begin
      failures++;
      $display("FAIL busy_release_second vld=%b slot4=%h required 0000010000 002",
               source_valid, source_addresses[4*AW +: AW]);
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = n_strobes;
    for (int k = 0; k < 4; k++) send(12'h300 + 12'(k), 12'h016 + 12'(k));
    repeat (3) @(negedge CLK);
    checks++;
    if (n_strobes - s0 != 4 || sb.size() != 0) begin
      failures++;
      $display("FAIL back_to_back strobes=%0d pending=%0d required 4 0", n_strobes - s0, sb.size());
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int s0;
    logic [11:0] o;
    acc = 0;
    neuron_busy = 10'b0000000001;
    for (int k = 0; k < 7; k++) begin
      o = 12'h100 + 12'(k);
      in_valid  = 1'b1;
      in_packet = {o, 12'h010};
      if (in_ready) begin
        sb.push_back('{0, o});
        acc++;
      end
      @(negedge CLK);
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 5 || in_ready !== 1'b0 || fifo_full !== 1'b1) begin
      failures++;
      $display("FAIL capacity accepted=%0d in_ready=%b full=%b required 5 0 1", acc, in_ready, fifo_full);
    end
    s0 = n_strobes;
    repeat (3) @(negedge CLK);
    checks++;
    if (n_strobes != s0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_stall strobes=%0d in_ready=%b required 0 0", n_strobes - s0, in_ready);
    end
    neuron_busy = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks++;
      if (source_valid !== 10'b0000000001) begin
        failures++;
        $display("FAIL drain_cycle%0d source_valid=%b required 0000000001", c, source_valid);
      end
      if (c == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL ready_after_pop in_ready=%b required 1", in_ready);
        end
      end
    end
    @(negedge CLK);
    checks++;
    if (source_valid !== '0 || n_strobes - s0 != 5) begin
      failures++;
      $display("FAIL drain_end vld=%b strobes=%0d required 0 5", source_valid, n_strobes - s0);
    end
  endtask

  task automatic test_clear_mid();
    int s0;
    neuron_busy = 10'b0000100000;
    for (int k = 0; k < 3; k++) send(12'h200 + 12'(k), 12'h015);
    checks++;
    if (fifo_empty !== 1'b0) begin
      failures++;
      $display("FAIL queued_before_clear empty=%b required 0", fifo_empty);
    end
    clear = 1'b1;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_during_clear in_ready=%b required 0", in_ready);
    end
    clear = 1'b0;
    neuron_busy = '0;
    sb.delete();
    exp_drops = 0;
    s0 = n_strobes;
    repeat (4) @(negedge CLK);
    checks++;
    if (fifo_empty !== 1'b1 || source_addresses !== '0 || drop_count !== 8'(exp_drops) ||
        n_strobes != s0) begin
      failures++;
      $display("FAIL clear_mid empty=%b addrs=%h drops=%0d strobes=%0d required 1 0 0 0",
               fifo_empty, source_addresses, drop_count, n_strobes - s0);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 260; k++) begin
      send(12'h0FF, 12'h000);
      if (k == 99) begin
        repeat (3) @(negedge CLK);
        checks++;
        if (drop_count !== 8'(exp_drops)) begin
          failures++;
          $display("FAIL drop_count_mid drops=%0d required %0d", drop_count, exp_drops);
        end
      end
    end
    repeat (4) @(negedge CLK);
    checks++;
    if (drop_count !== 8'(exp_drops)) begin
      failures++;
      $display("FAIL drop_saturate drops=%0d required %0d", drop_count, exp_drops);
    end
  endtask

  initial begin
    test_reset();
    test_basic_delivery();
    test_drops();
    test_busy();
    test_back_to_back();
    test_backpressure();
    test_clear_mid();
    test_saturate();
    repeat (3) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_packet_receiver.md
# spike_packet_receiver

Receive side of the spike-packet protocol. The block accepts 24-bit spike packets from the NoC on a valid/ready handshake and buffers them in a small FIFO. It decodes each packet's destination against the local neuron address range, then delivers the packet's origin address to the addressed neuron's source-address slot with a one-cycle strobe. It sits between the router port and the neuron array of an accelerator tile, opposite the network_interface that packs local spikes into outgoing packets.

## Interface
- NUM_NEURONS, 10, neurons in the tile; destination index range 0..NUM_NEURONS-1
- ADDR_W, 12, width of neuron addresses
- FIFO_DEPTH, 4, ingress FIFO entries; power of two, at least 2
- CLK  in  1  single clock; all state changes on rising edge
- clear  in  1  reset, synchronous, active-high
- base_address  in  ADDR_W  address of local neuron 0; static during operation
- in_valid  in  1  packet offered
- in_packet  in  2*ADDR_W  [23:12] origin (spiking neuron), [11:0] destination
- in_ready  out  1  packet accepted on an edge where in_valid && in_ready
- neuron_busy  in  NUM_NEURONS  neuron i cannot take a source address this cycle
- source_addresses  out  ADDR_W*NUM_NEURONS  slot i = bits [ADDR_W*(i+1)-1 : ADDR_W*i], last origin delivered to neuron i
- source_valid  out  NUM_NEURONS  one-hot, one-cycle strobe marking slot i updated
- drop_count  out  8  saturating count of out-of-range packets
- fifo_empty / fifo_full  out  1 each  FIFO status

## Operation
- in_ready = !fifo_full && !clear, driven combinationally from the FIFO count.
  - When full, no push occurs even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- FIFO read and write pointers are log2(FIFO_DEPTH) bits, wrap modulo depth, with a separate count of 0..FIFO_DEPTH.
- Delivery FSM states: IDLE and CHECK. A hold register holds the packet being checked.
  - IDLE: if !fifo_empty, pop the head into the hold register and go to CHECK. Otherwise stay in IDLE.
  - CHECK: compute idx = hold.dest - base_address, a 12-bit unsigned subtraction that wraps.
    - idx >= NUM_NEURONS (including wrap from dest < base): drop the packet and increment drop_count, saturating at 255. This counts as done.
    - neuron_busy[idx] = 1: stay in CHECK, hold unchanged, no pop (head-of-line blocking).
    - Otherwise: source_addresses slot idx <= hold.origin, and source_valid[idx] = 1 for the next cycle only. This counts as done.
    - On done: if !fifo_empty, pop the next packet into hold and stay in CHECK. Otherwise go to IDLE.
- Other slots keep their values. source_valid is all-zero in any cycle without a delivery.
- At most one delivery per cycle; source_valid is never more than one-hot.

## Timing
- Reset (clear high at an edge):
  - FIFO empty, pointers 0, state IDLE, hold cleared.
  - source_addresses all 0, source_valid 0, drop_count 0.
  - in_ready is 0 while clear is high and 1 in the first cycle after.
- Reset mid-operation discards all FIFO and hold contents. No strobe is emitted on the clearing edge or after it.
- Latency: a packet accepted at edge E0 with an empty FIFO, state IDLE and no busy:
  - popped at E1;
  - slot written and source_valid high in the cycle following E2.
- Steady-state throughput is one packet per cycle while no neuron is busy and no packet is out of range.
- Capacity is FIFO_DEPTH + 1 packets in flight: FIFO plus hold register.

## Structure
- Shared package: ADDR_W, PKT_W = 2*ADDR_W, and field bounds ORIGIN_MSB/LSB = 23/12 and DEST_MSB/LSB = 11/0. network_interface imports the same definitions.
- Sub-module: spike_packet_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count.
- The FSM, range check and output registers stay in the top module.

## Test plan
- base=0x010; send {0x0A3,0x013} -> two edges after acceptance, slot 3 = 0x0A3 and source_valid = 10'b0000001000 for exactly one cycle.
- Send dest 0x01A (idx 10), then dest 0x00F (wraps to 0xFFF) -> no strobe; drop_count = 2.
- Hold neuron_busy[3]=1 and send {0x001,0x013} then {0x002,0x014}:
  - no strobes while busy;
  - drop busy -> slot 3 = 0x001 on the next cycle, slot 4 = 0x002 on the cycle after.
- Keep busy[0]=1 and offer 7 packets to dest 0x010 back-to-back:
  - 5 accepted (4 in FIFO, 1 in hold), in_ready low from then on;
  - release busy -> 5 strobes on consecutive cycles, in_ready high again after the first pop.
- With 3 packets queued, assert clear for one cycle -> no strobes afterward, fifo_empty=1, all slots 0, drop_count 0.
- Send 260 out-of-range packets -> drop_count stops at 255.
